// File: rtl/mpe_operand_feeder.sv
// Streams cmd_len operand beats from SRAM (base, base+1, ...) into a small FIFO
// and on to the matrix PE over a valid/ready interface, with a done pulse per burst.
module mpe_operand_feeder #(
    parameter int DATA_W     = 512,
    parameter int ADDR_W     = 12,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              sram_rd_en,
    output logic [ADDR_W-1:0] sram_rd_addr,
    input  logic [DATA_W-1:0] sram_rd_data,
    output logic [DATA_W-1:0] mpe_data,
    output logic              mpe_valid,
    input  logic              mpe_ready,
    output logic              mpe_last,
    output logic              done,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and data/last hold while valid && !ready.

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued_cnt;
    logic [LEN_W-1:0]  out_cnt;
    logic              rd_en_r;
    logic              rd_en_q;
    logic              done_r;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    logic              accept;
    logic              push;
    logic              pop;
    logic              last_issue;
    logic              room_nxt;
    logic [LEN_W-1:0]  issued_nxt;
    logic [CNT_W-1:0]  count_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Outputs are masked by rst so they read idle for every cycle reset is high.
    assign cmd_ready    = (state == IDLE) && !rst;
    assign accept       = cmd_valid && cmd_ready;
    assign sram_rd_en   = rd_en_r && !rst;
    assign sram_rd_addr = rd_addr_q;
    assign mpe_valid    = (fifo_count != '0) && !rst;
    assign mpe_data     = mpe_valid ? fifo_mem[rd_ptr] : '0;
    assign mpe_last     = mpe_valid && (out_cnt == len_q - LEN_W'(1));
    assign done         = done_r && !rst;
    assign dbg_state    = state;

    assign push       = rd_en_q;
    assign pop        = mpe_valid && mpe_ready;
    assign issued_nxt = issued_cnt + LEN_W'(sram_rd_en);
    assign last_issue = sram_rd_en && (issued_nxt == len_q);
    assign count_nxt  = fifo_count + CNT_W'(push) - CNT_W'(pop);

    // Next cycle may issue only if the entries held plus the read still in flight
    // leave a free slot for the new read's data.
    assign room_nxt = ({1'b0, count_nxt} + (CNT_W + 1)'(sram_rd_en))
                      < (CNT_W + 1)'(FIFO_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_cnt <= '0;
            out_cnt    <= '0;
            rd_en_r    <= 1'b0;
            rd_addr_q  <= '0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (pop) begin
                out_cnt <= out_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cmd_len != '0) begin
                            state      <= RUN;
                            base_q     <= cmd_base_addr;
                            len_q      <= cmd_len;
                            issued_cnt <= '0;
                            out_cnt    <= '0;
                            rd_en_r    <= 1'b1;
                            rd_addr_q  <= cmd_base_addr;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    issued_cnt <= issued_nxt;
                    rd_addr_q  <= base_q + ADDR_W'(issued_nxt);
                    if (last_issue) begin
                        state   <= DRAIN;
                        rd_en_r <= 1'b0;
                    end else begin
                        rd_en_r <= room_nxt;
                    end
                end
                DRAIN: begin
                    if (pop && mpe_last) begin
                        state  <= IDLE;
                        done_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // rd_en_q marks that sram_rd_data carries a requested word this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_q    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            rd_en_q    <= sram_rd_en;
            fifo_count <= count_nxt;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_mem[wr_ptr] <= sram_rd_data;
        end
    end

endmodule

// File: tb/tb_mpe_operand_feeder.sv
// Directed bench for mpe_operand_feeder: SRAM model returns word[a] = a, expected
// beats and read addresses are queued at command issue and checked by a monitor.
module tb_mpe_operand_feeder;

    localparam int DATA_W = 512;
    localparam int ADDR_W = 12;
    localparam int LEN_W  = 8;
    localparam int DEPTH  = 4;
    localparam int W      = DATA_W + 1;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              sram_rd_en;
    logic [ADDR_W-1:0] sram_rd_addr;
    logic [DATA_W-1:0] sram_rd_data;
    logic [DATA_W-1:0] mpe_data;
    logic              mpe_valid;
    logic              mpe_ready;
    logic              mpe_last;
    logic              done;
    logic [1:0]        dbg_state;

    mpe_operand_feeder #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base_addr(cmd_base_addr), .cmd_len(cmd_len),
        .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
        .mpe_data(mpe_data), .mpe_valid(mpe_valid), .mpe_ready(mpe_ready),
        .mpe_last(mpe_last), .done(done), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM: data for the address presented with rd_en appears the next cycle
    initial sram_rd_data = '0;
    always @(posedge clk) begin
        if (sram_rd_en) sram_rd_data <= DATA_W'(sram_rd_addr);
    end

    int total;
    int bad;
    logic [W-1:0]      exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    int reads_total;
    int pops_total;
    bit hs_last_prev;
    bit zero_arm;
    bit stall_prev;
    logic [DATA_W-1:0] stall_data;
    logic              stall_last;
    logic [W-1:0]      mon_e;
    logic [ADDR_W-1:0] mon_a;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // scoreboard monitor, sampling away from the active edge
    always @(negedge clk) begin
        check("done_pulse", done, hs_last_prev | zero_arm);
        zero_arm = 1'b0;
        if (sram_rd_en) begin
            reads_total++;
            if (exp_addr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_read: got addr %0h required no read", sram_rd_addr);
            end else begin
                mon_a = exp_addr_q.pop_front();
                check("rd_addr", sram_rd_addr, mon_a);
            end
        end
        check("occupancy_le_depth", (reads_total - pops_total) <= DEPTH, 1);
        if (stall_prev) begin
            total++;
            if (!(mpe_valid === 1'b1 && mpe_data === stall_data && mpe_last === stall_last)) begin
                bad++;
                $display("FAIL stall_hold: got valid=%0b last=%0b data=%0h required valid=1 last=%0b data=%0h",
                         mpe_valid, mpe_last, mpe_data[31:0], stall_last, stall_data[31:0]);
            end
        end
        if (mpe_valid && mpe_ready) begin
            pops_total++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL extra_beat: got data=%0h required no beat", mpe_data[31:0]);
            end else begin
                mon_e = exp_q.pop_front();
                if ({mpe_last, mpe_data} !== mon_e) begin
                    bad++;
                    $display("FAIL beat: got last=%0b data=%0h required last=%0b data=%0h",
                             mpe_last, mpe_data[31:0], mon_e[DATA_W], mon_e[31:0]);
                end
            end
        end
        hs_last_prev = mpe_valid && mpe_ready && mpe_last;
        stall_prev   = mpe_valid && !mpe_ready;
        stall_data   = mpe_data;
        stall_last   = mpe_last;
    end

    // driver tasks
    task automatic send_cmd(input logic [ADDR_W-1:0] base, input int len);
        int n;
        logic [ADDR_W-1:0] a;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        cmd_valid     = 1'b1;
        cmd_base_addr = base;
        cmd_len       = LEN_W'(len);
        for (int i = 0; i < len; i++) begin
            a = base + ADDR_W'(i);
            exp_addr_q.push_back(a);
            exp_q.push_back({(i == len - 1), DATA_W'(a)});
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (len == 0) zero_arm = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        check("done_within_budget", done, 1);
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 0);
        check({tag, "_sram_rd_en"}, sram_rd_en, 0);
        check({tag, "_mpe_valid"}, mpe_valid, 0);
        check({tag, "_mpe_last"}, mpe_last, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_mpe_data_zero"}, (mpe_data === '0), 1);
    endtask

    initial begin
        int n;
        int first_n;
        int done_n;
        int k;
        int r0;
        int p0;
        logic [3:0] pat;
        total = 0; bad = 0; reads_total = 0; pops_total = 0;
        hs_last_prev = 0; zero_arm = 0; stall_prev = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_base_addr = '0; cmd_len = '0; mpe_ready = 1'b0;
        pat = 4'b1001;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_outputs("reset");
        check("reset_rd_addr", sram_rd_addr, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", cmd_ready, 1);

        // base 0x010 len 4, ready high: beats at T+3..T+6, done at T+7
        @(posedge clk);
        #1 mpe_ready = 1'b1;
        send_cmd(12'h010, 4);
        n = 0; first_n = 0; done_n = 0;
        while (n < 40 && done_n == 0) begin
            @(negedge clk);
            n++;
            if (mpe_valid && first_n == 0) first_n = n;
            if (done) done_n = n;
        end
        check("t1_first_valid_cycle", first_n, 3);
        check("t1_done_cycle", done_n, 7);
        check("t1_ready_with_done", cmd_ready, 1);

        // len 8 with ready pattern 1,0,0,1
        send_cmd(12'h100, 8);
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            if (done) break;
            @(posedge clk);
            #1;
            k++;
            mpe_ready = pat[k % 4];
        end
        check("t2_done", done, 1);
        @(posedge clk);
        #1 mpe_ready = 1'b1;

        // address wrap
        send_cmd(12'hFFE, 4);
        wait_done(40);

        // zero-length command
        send_cmd(12'h055, 0);
        @(negedge clk);
        check("t4_done_next_cycle", done, 1);
        check("t4_ready_held", cmd_ready, 1);
        @(negedge clk);
        check("t4_done_single", done, 0);
        check("t4_ready_still", cmd_ready, 1);

        // len 16 with ready low for 10 cycles: only DEPTH reads may issue
        @(posedge clk);
        #1 mpe_ready = 1'b0;
        r0 = reads_total;
        send_cmd(12'h200, 16);
        repeat (10) @(negedge clk);
        check("t5_reads_while_stalled", reads_total - r0, 4);
        check("t5_valid_while_stalled", mpe_valid, 1);
        @(posedge clk);
        #1 mpe_ready = 1'b1;
        wait_done(100);

        // reset after 3 beats of a len-8 burst, then a fresh len-2 burst
        p0 = pops_total;
        send_cmd(12'h300, 8);
        n = 0;
        while ((pops_total - p0) < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6_three_beats", (pops_total - p0) >= 3, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        exp_addr_q.delete();
        pops_total = reads_total;
        hs_last_prev = 0;
        stall_prev = 0;
        @(negedge clk);
        reset_outputs("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_ready_after_rst", cmd_ready, 1);
        check("t6_valid_after_rst", mpe_valid, 0);
        repeat (3) begin
            @(negedge clk);
            check("t6_no_stale_valid", mpe_valid, 0);
        end
        send_cmd(12'h020, 2);
        wait_done(40);

        repeat (3) @(negedge clk);
        check("beats_left", exp_q.size(), 0);
        check("reads_left", exp_addr_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test required end within time limit");
        $fatal(1);
    end

endmodule
